// File: rtl/mux_n_arb.sv
// rtl/mux_n_arb.sv - N-channel valid/ready mux with external-select or round-robin grant
// Registered output stage; one transfer per cycle when the consumer keeps up.
module mux_n_arb #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int MODE   = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  input  logic [CH_NUM-1:0]        in_valid,
  output logic [CH_NUM-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_ch;
  logic              r_valid;
  logic [SEL_W-1:0]  r_last_grant;

  logic              w_load_en;
  logic              w_grant_found;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [DATA_W-1:0] w_grant_data;
  logic              w_xfer;

  assign w_load_en = !r_valid || out_ready;

  // Grant search: in round-robin mode, the k-th candidate after the last grant wins
  // if it is the first valid one found.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_grant_data  = '0;
    if (MODE == 0) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          w_grant_found = 1'b1;
          w_grant_idx   = SEL_W'(i);
          w_grant_data  = in_data[i*DATA_W +: DATA_W];
        end
      end
    end else begin
      for (int k = 1; k <= CH_NUM; k++) begin
        for (int i = 0; i < CH_NUM; i++) begin
          if (!w_grant_found && in_valid[i] &&
              i == (int'(r_last_grant) + k) % CH_NUM) begin
            w_grant_found = 1'b1;
            w_grant_idx   = SEL_W'(i);
            w_grant_data  = in_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign w_xfer = sys_rst_n && w_load_en && w_grant_found;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      in_ready[i] = w_xfer && (w_grant_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_ch         <= '0;
      r_last_grant <= SEL_W'(CH_NUM - 1);
    end else if (w_load_en) begin
      if (w_grant_found) begin
        r_valid <= 1'b1;
        r_data  <= w_grant_data;
        r_ch    <= w_grant_idx;
        if (MODE != 0) begin
          r_last_grant <= w_grant_idx;
        end
      end else begin
        // Drained with nothing to refill: data and channel keep their last values.
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_n_arb.sv
// tb/tb_mux_n_arb.sv - bench for mux_n_arb: round-robin 4ch, select 4ch, select 3ch
// Shared stimulus drives all three instances; each has its own behavioural model.
module tb_mux_n_arb;

  logic        sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        sys_rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  rdy_a, rdy_b;
  logic [2:0]  rdy_c;
  logic [7:0]  od_a, od_b, od_c;
  logic [1:0]  oc_a, oc_b, oc_c;
  logic        ov_a, ov_b, ov_c;

  mux_n_arb #(.CH_NUM(4), .DATA_W(8), .SEL_W(2), .MODE(1)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_a), .sel(sel), .out_data(od_a), .out_ch(oc_a), .out_valid(ov_a),
    .out_ready(out_ready));

  mux_n_arb #(.CH_NUM(4), .DATA_W(8), .SEL_W(2), .MODE(0)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_b), .sel(sel), .out_data(od_b), .out_ch(oc_b), .out_valid(ov_b),
    .out_ready(out_ready));

  mux_n_arb #(.CH_NUM(3), .DATA_W(8), .SEL_W(2), .MODE(0)) u_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data[23:0]),
    .in_valid(in_valid[2:0]), .in_ready(rdy_c), .sel(sel), .out_data(od_c), .out_ch(oc_c),
    .out_valid(ov_c), .out_ready(out_ready));

  int n_checks = 0;
  int n_errors = 0;

  int m_valid[3];
  int m_data[3];
  int m_ch[3];
  int m_last[3];

  function automatic int mode_of(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int n_of(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  // Channel that would be granted, or -1.
  function automatic int pick(int mode, int n, int s, logic [3:0] v, int last);
    if (mode == 0) begin
      if (s < n && v[s]) return s;
      return -1;
    end
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (last + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int k);
    int g;
    if (!sys_rst_n) return 4'b0;
    if (m_valid[k] == 1 && !out_ready) return 4'b0;
    g = pick(mode_of(k), n_of(k), int'(sel), in_valid, m_last[k]);
    if (g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 0; m_data[k] = 0; m_ch[k] = 0; m_last[k] = n_of(k) - 1;
    end
  end

  always @(posedge sys_clk) begin
    for (int k = 0; k < 3; k++) begin
      int g;
      if (!sys_rst_n) begin
        m_valid[k] = 0; m_data[k] = 0; m_ch[k] = 0; m_last[k] = n_of(k) - 1;
      end else if (m_valid[k] == 0 || out_ready) begin
        g = pick(mode_of(k), n_of(k), int'(sel), in_valid, m_last[k]);
        if (g >= 0) begin
          m_valid[k] = 1;
          m_data[k]  = int'(in_data[g*8 +: 8]);
          m_ch[k]    = g;
          if (mode_of(k) == 1) m_last[k] = g;
        end else begin
          m_valid[k] = 0;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_inst(int k, logic [3:0] rdy, logic v, logic [7:0] d, logic [1:0] c);
    chk($sformatf("i%0d_in_ready", k), 32'(rdy), 32'(exp_ready(k)));
    chk($sformatf("i%0d_out_valid", k), 32'(v), 32'(m_valid[k]));
    chk($sformatf("i%0d_out_data", k), 32'(d), 32'(m_data[k]));
    chk($sformatf("i%0d_out_ch", k), 32'(c), 32'(m_ch[k]));
  endtask

  always @(negedge sys_clk) begin
    cmp_inst(0, rdy_a, ov_a, od_a, oc_a);
    cmp_inst(1, rdy_b, ov_b, od_b, oc_b);
    cmp_inst(2, {1'b0, rdy_c}, ov_c, od_c, oc_c);
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  int cnt[4];

  initial begin
    sys_rst_n = 1'b0; in_valid = 4'hF; in_data = 32'h44332211; sel = 2'd0; out_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_in_ready", 32'(rdy_a), 32'h0);
    chk("rst_out_valid", 32'(ov_a), 32'h0);
    chk("rst_out_data", 32'(od_a), 32'h0);
    chk("rst_out_ch", 32'(oc_a), 32'h0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("first_grant", 32'(rdy_a), 32'h1);

    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_ch", 32'(oc_a), 32'(i % 4));
      chk("rr_data", 32'(od_a), 32'(17 * (i % 4 + 1)));
      chk("rr_valid", 32'(ov_a), 32'h1);
    end

    out_ready = 1'b0;
    repeat (5) begin
      cyc();
      chk("bp_data", 32'(od_a), 32'h22);
      chk("bp_ch", 32'(oc_a), 32'h1);
      chk("bp_in_ready", 32'(rdy_a), 32'h0);
    end
    out_ready = 1'b1;
    @(negedge sys_clk);
    chk("bp_release_ready", 32'(rdy_a), 32'h4);
    cyc();
    chk("bp_next_ch", 32'(oc_a), 32'h2);

    in_valid = 4'b0100;
    repeat (3) begin
      @(negedge sys_clk);
      chk("sparse_ready", 32'(rdy_a), 32'h4);
      cyc();
      chk("sparse_ch", 32'(oc_a), 32'h2);
      chk("sparse_valid", 32'(ov_a), 32'h1);
    end
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("pair_ch", 32'(oc_a), (i % 2 == 0) ? 32'h3 : 32'h0);
    end

    sel = 2'd3; in_valid = 4'b0101;
    @(negedge sys_clk);
    chk("sel3_ready_b", 32'(rdy_b), 32'h0);
    chk("sel3_ready_c", 32'(rdy_c), 32'h0);
    cyc();
    chk("sel3_valid_b", 32'(ov_b), 32'h0);
    chk("sel3_valid_c", 32'(ov_c), 32'h0);
    chk("sel3_hold_data_b", 32'(od_b), 32'h11);
    in_valid = 4'hF;
    @(negedge sys_clk);
    chk("sel3_all_ready_b", 32'(rdy_b), 32'h8);
    chk("sel3_all_ready_c", 32'(rdy_c), 32'h0);
    cyc();
    chk("sel3_ch_b", 32'(oc_b), 32'h3);
    chk("sel3_valid_c2", 32'(ov_c), 32'h0);

    in_data = 32'hD4C3B2A1; sel = 2'd2; in_valid = 4'b0101;
    @(negedge sys_clk);
    chk("sel2_ready_b", 32'(rdy_b), 32'h4);
    cyc();
    chk("sel2_data_b", 32'(od_b), 32'hC3);
    chk("sel2_ch_b", 32'(oc_b), 32'h2);

    out_ready = 1'b0; sel = 2'd1; in_valid = 4'hF;
    repeat (2) begin
      cyc();
      chk("selbp_ch_b", 32'(oc_b), 32'h2);
      chk("selbp_data_b", 32'(od_b), 32'hC3);
    end
    out_ready = 1'b1;
    cyc();
    chk("selnew_ch_b", 32'(oc_b), 32'h1);
    chk("selnew_data_b", 32'(od_b), 32'hB2);

    out_ready = 1'b0;
    cyc();
    chk("mid_valid_pre", 32'(ov_a), 32'h1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("mid_rst_ready", 32'(rdy_a), 32'h0);
    cyc();
    chk("mid_rst_valid", 32'(ov_a), 32'h0);
    chk("mid_rst_data", 32'(od_a), 32'h0);
    sys_rst_n = 1'b1; out_ready = 1'b1;
    @(negedge sys_clk);
    chk("mid_restart_ready", 32'(rdy_a), 32'h1);
    cyc();
    chk("mid_restart_ch", 32'(oc_a), 32'h0);
    chk("mid_restart_data", 32'(od_a), 32'hA1);

    for (int i = 0; i < 4; i++) cnt[i] = 0;
    repeat (8) begin
      cyc();
      cnt[oc_a]++;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("fair_ch%0d", i), 32'(cnt[i]), 32'h2);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_n_arb.md
Name: mux_n_arb

Overview:
Parametrised N-channel, W-bit multiplexer that generalises the team's combinational 2:1 mux. It adds a per-channel valid/ready handshake, a registered output stage and two channel-selection modes:
- external select
- fair round-robin arbitration

It sits between several producers and one consumer, for example merging sensor or UART byte streams onto one bus.

Parameters:
CH_NUM, 4, number of input channels (2..16)
DATA_W, 8, data width per channel (1..32)
SEL_W, 2, channel index width; must equal clog2(CH_NUM) (min 1)
MODE, 1, 0 = external select via sel, 1 = round-robin arbitration

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  synchronous active-low reset
in_data  in  CH_NUM*DATA_W  packed inputs, channel i at [i*DATA_W +: DATA_W]
in_valid  in  CH_NUM  per-channel data valid
in_ready  out  CH_NUM  per-channel accept, at most one bit high
sel  in  SEL_W  channel select, used only when MODE=0
out_data  out  DATA_W  registered selected data
out_ch  out  SEL_W  channel index of out_data
out_valid  out  1  out_data valid
out_ready  in  1  consumer accept

Behaviour:
- Clock and reset: one clock (sys_clk). Reset is synchronous and active-low (sys_rst_n), sampled on the rising edge.
- Reset values: out_valid=0, out_data=0, out_ch=0, last_grant=CH_NUM-1 (so channel 0 has first priority). in_ready is forced to all-zero while sys_rst_n=0.
- Load enable: load_en = !out_valid || out_ready. The output register may take new data only when empty or being drained in the same cycle.
- Grant, MODE=0: request channel is sel. A grant exists only if sel<CH_NUM and in_valid[sel]=1. If sel>=CH_NUM there is never a grant.
- Grant, MODE=1: search channels last_grant+1, last_grant+2, ... modulo CH_NUM. The first channel with in_valid=1 is granted.
- in_ready[g] = load_en && grant_exists, for the granted channel only (one-hot or zero). in_ready is combinational from in_valid, sel, out_ready and state; no combinational path from in_data.
- Transfer: occurs when in_valid[g] && in_ready[g]. At the next edge: out_data<=in_data[g], out_ch<=g, out_valid<=1. In MODE=1, last_grant<=g.
  - last_grant updates only on a transfer; MODE=0 never updates it.
- Drain without refill: load_en=1 and no grant: out_valid<=0 at the next edge. out_data and out_ch hold their last values.
- Backpressure: out_valid=1 and out_ready=0: out_data, out_ch and out_valid hold, in_ready is all-zero, last_grant holds.
- Throughput and latency: one transfer per cycle at full rate, no bubbles, including repeated grants to a single active channel. Latency is input handshake to out_valid in 1 cycle.
- Wrap-around: the round-robin pointer wraps from CH_NUM-1 to 0.
- Fairness: with all channels continuously valid, each channel gets exactly 1 grant per CH_NUM transfers.
- Simultaneous drain and refill: out_ready=1 with a grant in the same cycle replaces the register contents; out_valid stays 1.
- sel changes while backpressured: no effect on held output. The new sel applies at the next load_en cycle.
- Reset mid-operation: held output data is discarded at the reset edge and all reset values apply. No transfer is accepted in a reset cycle.
- A producer that deasserts in_valid before handshake loses nothing; the channel is simply not granted.

Test Plan:
1. Reset: sys_rst_n=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0000, out_valid=0, out_data=0, out_ch=0. After release, first grant is ch0.
2. MODE=1, in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=1111, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, out_data 11,22,33,44,11,22, out_valid constantly 1.
3. Backpressure: during scenario 2, out_ready=0 for 5 cycles with out_ch=1 held -> out_data=22 stable, in_ready=0000. After out_ready=1, next out_ch=2.
4. Sparse: only in_valid[2]=1, out_ready=1 -> in_ready=0100 every cycle, out_ch=2 each cycle, no bubbles. Then in_valid=1001 -> out_ch order 3,0,3,0.
5. MODE=0: sel=3, in_valid=0101 -> no transfer, out_valid falls to 0. sel=2 -> in_ready=0100, next cycle out_data=in_data ch2, out_ch=2. sel=3 with CH_NUM=3 -> never granted.
6. Reset mid-stream: assert sys_rst_n=0 for 1 cycle while out_valid=1, out_ready=0 -> next edge out_valid=0. After release, round-robin restarts at ch0.
